// File: rtl/scan_reg_pkg.sv
// Shared constants and sizing helpers for the scan register bank.
// SCAN_REG_PARITY_EN selects the parity shadow bit build.
package scan_reg_pkg;

`ifdef SCAN_REG_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Every reset-time register bit takes this value.
  localparam logic RST_VAL = 1'b0;

  function automatic int chain_len(input int seg, input bit parity);
    return seg + (parity ? 1 : 0);
  endfunction

  function automatic int cnt_width(input int chain);
    return (chain < 1) ? 1 : $clog2(chain + 1);
  endfunction

endpackage

// File: rtl/scan_reg_bank_if.sv
// Functional and scan-path signals of the scan register bank.
// No handshake: inputs are sampled on every rising CLK edge; outputs come from registers.
interface scan_reg_bank_if #(
  parameter int WIDTH  = 8,
  parameter int NCHAIN = 1
);
  logic              SE;
  logic [NCHAIN-1:0] SI;
  logic              EN;
  logic [WIDTH-1:0]  D;
  logic [WIDTH-1:0]  Q;
  logic [NCHAIN-1:0] SO;
  logic              SDONE;
  logic              PERR;

  modport master (output SE, SI, EN, D, input Q, SO, SDONE, PERR);
  modport slave  (input SE, SI, EN, D, output Q, SO, SDONE, PERR);
endinterface

// File: rtl/scan_reg_seg.sv
// One SEG-bit scan segment: shifts from SI toward bit 0, or loads D, with async reset.
module scan_reg_seg
  import scan_reg_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic           i_clk,
  input  logic           i_rn,
  input  logic           i_se,
  input  logic           i_en,
  input  logic           i_si,
  input  logic [SEG-1:0] i_d,
  output logic [SEG-1:0] o_q,
  output logic           o_so
);

  logic [SEG-1:0] r_q;
  logic [SEG-1:0] w_shift;

  // Written with shifts so a single-bit segment needs no special case.
  assign w_shift = (r_q >> 1) | (SEG'(i_si) << (SEG - 1));

  always_ff @(posedge i_clk or negedge i_rn) begin
    if (!i_rn) begin
      r_q <= {SEG{RST_VAL}};
    end else if (i_se) begin
      r_q <= w_shift;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q  = r_q;
  assign o_so = r_q[0];

endmodule

// File: rtl/scan_reg_bank.sv
// Multi-chain scan register bank with shift counter and unload-done pulse.
// SCAN_REG_PARITY_EN adds a parity shadow bit at the tail of segment 0 and PERR.
module scan_reg_bank
  import scan_reg_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NCHAIN = 1
) (
  input  logic             CLK,
  input  logic             RN,
  scan_reg_bank_if.slave   bus
);

  localparam int SEG       = WIDTH / NCHAIN;
  localparam int CHAIN_LEN = chain_len(SEG, PARITY_EN);
  localparam int CW        = cnt_width(CHAIN_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);

  logic [WIDTH-1:0]  w_q;
  logic [NCHAIN-1:0] w_seg_so;
  logic [NCHAIN-1:0] w_so;
  logic              w_perr;
  logic [CW-1:0]     r_cnt;
  logic              r_sdone;

  for (genvar c = 0; c < NCHAIN; c++) begin : g_seg
    scan_reg_seg #(.SEG(SEG)) u_seg (
      .i_clk (CLK),
      .i_rn  (RN),
      .i_se  (bus.SE),
      .i_en  (bus.EN),
      .i_si  (bus.SI[c]),
      .i_d   (bus.D[c*SEG +: SEG]),
      .o_q   (w_q[c*SEG +: SEG]),
      .o_so  (w_seg_so[c])
    );
  end

`ifdef SCAN_REG_PARITY_EN
  logic r_p;

  // P extends segment 0: it catches Q[0] on a shift and becomes SO[0].
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_p <= RST_VAL;
    end else if (bus.SE) begin
      r_p <= w_q[0];
    end else if (bus.EN) begin
      r_p <= ^bus.D;
    end
  end

  always_comb begin
    w_so    = w_seg_so;
    w_so[0] = r_p;
  end

  assign w_perr = (^w_q) ^ r_p;
`else
  assign w_so   = w_seg_so;
  assign w_perr = 1'b0;
`endif

  // Counts consecutive shift edges; any functional edge discards a partial unload.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_cnt   <= '0;
      r_sdone <= RST_VAL;
    end else if (bus.SE) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_sdone <= 1'b1;
      end else begin
        r_cnt   <= r_cnt + CW'(1);
        r_sdone <= 1'b0;
      end
    end else begin
      r_cnt   <= '0;
      r_sdone <= 1'b0;
    end
  end

  assign bus.Q     = w_q;
  assign bus.SO    = w_so;
  assign bus.SDONE = r_sdone;
  assign bus.PERR  = w_perr;

endmodule

// File: tb/tb_scan_reg_bank.sv
// Randomized bench for scan_reg_bank against a chain-of-bits queue model.
// Build with or without SCAN_REG_PARITY_EN; the model follows the same macro.
module tb_scan_reg_bank;

  localparam int W   = 8;
  localparam int NC  = 2;
  localparam int SEG = W / NC;
`ifdef SCAN_REG_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int CL = SEG + (PAR ? 1 : 0);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rn;
  always #5 clk = ~clk;

  scan_reg_bank_if #(.WIDTH(W), .NCHAIN(NC)) bus ();

  scan_reg_bank #(.WIDTH(W), .NCHAIN(NC)) dut (
    .CLK (clk),
    .RN  (rn),
    .bus (bus)
  );

  // ---------------- reference model ----------------
  // chain_q[c][0] is the bit presented on SO[c]; new bits enter at the back.
  bit chain_q [NC][$];
  int run_len;
  bit exp_sdone;
  int n_vec = 0;
  int n_err = 0;

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      chain_q[c].delete();
      for (int k = 0; k < SEG + ((PAR && c == 0) ? 1 : 0); k++) chain_q[c].push_back(1'b0);
    end
    run_len   = 0;
    exp_sdone = 1'b0;
  endfunction

  function automatic void model_load(input logic [W-1:0] d);
    for (int c = 0; c < NC; c++) begin
      chain_q[c].delete();
      if (PAR && c == 0) chain_q[c].push_back(^d);
      for (int k = 0; k < SEG; k++) chain_q[c].push_back(d[c*SEG + k]);
    end
  endfunction

  function automatic void model_edge(input logic se, input logic en,
                                     input logic [W-1:0] d, input logic [NC-1:0] si);
    if (se) begin
      for (int c = 0; c < NC; c++) begin
        void'(chain_q[c].pop_front());
        chain_q[c].push_back(si[c]);
      end
      run_len++;
      exp_sdone = (run_len % CL) == 0;
    end else begin
      run_len   = 0;
      exp_sdone = 1'b0;
      if (en) model_load(d);
    end
  endfunction

  function automatic logic [W-1:0] model_q();
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < NC; c++) begin
      int off;
      off = (PAR && c == 0) ? 1 : 0;
      for (int k = 0; k < SEG; k++) r[c*SEG + k] = chain_q[c][k + off];
    end
    return r;
  endfunction

  function automatic logic [NC-1:0] model_so();
    logic [NC-1:0] r;
    for (int c = 0; c < NC; c++) r[c] = chain_q[c][0];
    return r;
  endfunction

  function automatic logic model_perr();
    logic x;
    x = 1'b0;
    if (PAR) begin
      for (int c = 0; c < NC; c++)
        foreach (chain_q[c][k]) x ^= chain_q[c][k];
    end
    return x;
  endfunction

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".q"},     32'(bus.Q),     32'(model_q()));
    check_val({tag, ".so"},    32'(bus.SO),    32'(model_so()));
    check_val({tag, ".sdone"}, 32'(bus.SDONE), 32'(exp_sdone));
    check_val({tag, ".perr"},  32'(bus.PERR),  32'(model_perr()));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic se, input logic en, input logic [W-1:0] d,
                      input logic [NC-1:0] si, input string tag);
    bus.SE = se;
    bus.EN = en;
    bus.D  = d;
    bus.SI = si;
    @(posedge clk);
    model_edge(se, en, d, si);
    #1;
    check_all(tag);
  endtask

  // Pulls RN low between edges and checks the outputs clear without a clock.
  task automatic reset_mid(input string tag);
    #2 rn = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    check_val({tag, ".q0"}, 32'(bus.Q), 32'h0);
    #1 rn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NC-1:0] si_lb;
    rn     = 1'b0;
    bus.SE = 1'b0;
    bus.EN = 1'b0;
    bus.D  = '0;
    bus.SI = '0;
    model_reset();
    #12;
    check_all("reset");
    rn = 1'b1;

    // load / hold
    step(1'b0, 1'b1, 8'hA5, 2'b00, "load");
    check_val("load_a5", 32'(bus.Q), 32'hA5);
    step(1'b0, 1'b0, 8'hFF, 2'b00, "hold");
    check_val("hold_a5", 32'(bus.Q), 32'hA5);

    // full unload with zeros shifted in
    for (int i = 0; i < CL; i++) step(1'b1, 1'b0, 8'h00, 2'b00, "unload");
    check_val("unload_done", 32'(bus.SDONE), 32'h1);
`ifndef SCAN_REG_PARITY_EN
    check_val("unload_q0", 32'(bus.Q), 32'h00);
`endif
    step(1'b0, 1'b0, 8'h00, 2'b00, "unload_end");

    // shift has priority over load
    step(1'b0, 1'b1, 8'h00, 2'b00, "clr");
    step(1'b1, 1'b1, 8'hFF, 2'b11, "se_en");
    check_val("shift_wins", 32'(bus.Q), 32'h88);
    step(1'b0, 1'b0, 8'h00, 2'b00, "se_en_end");

    // partial shift is discarded by an SE gap
    step(1'b1, 1'b0, 8'h00, 2'b01, "partial");
    step(1'b1, 1'b0, 8'h00, 2'b10, "partial");
    step(1'b0, 1'b0, 8'h00, 2'b00, "gap");
    for (int i = 0; i < CL; i++) begin
      step(1'b1, 1'b0, 8'h00, 2'(i), "resume");
      if (i == CL - 2) check_val("resume_early", 32'(bus.SDONE), 32'h0);
    end
    check_val("resume_done", 32'(bus.SDONE), 32'h1);
    step(1'b0, 1'b0, 8'h00, 2'b00, "resume_end");

    // reset in the middle of a shift
    step(1'b0, 1'b1, 8'hA5, 2'b00, "pre_rst");
    step(1'b1, 1'b0, 8'h00, 2'b11, "pre_rst_sh");
    reset_mid("rst_mid");
    for (int i = 0; i < CL; i++) step(1'b1, 1'b0, 8'h00, 2'b01, "post_rst");
    check_val("post_rst_done", 32'(bus.SDONE), 32'h1);

`ifdef SCAN_REG_PARITY_EN
    step(1'b0, 1'b1, 8'h07, 2'b00, "par_load");
    check_val("par_p", 32'(bus.SO[0]), 32'h1);
    check_val("par_perr", 32'(bus.PERR), 32'h0);
    for (int i = 0; i < CL; i++) step(1'b1, 1'b0, 8'h00, model_so(), "loopback");
    check_val("loop_q", 32'(bus.Q), 32'h07);
    check_val("loop_perr", 32'(bus.PERR), 32'h0);
    check_val("loop_done", 32'(bus.SDONE), 32'h1);
    step(1'b0, 1'b0, 8'h00, 2'b00, "loop_end");
    for (int i = 0; i < CL; i++) begin
      si_lb = model_so();
      if (i == 1) si_lb[1] = 1'b1;
      step(1'b1, 1'b0, 8'h00, si_lb, "corrupt");
    end
    check_val("corrupt_perr", 32'(bus.PERR), 32'h1);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic se, en;
      se = ($urandom_range(0, 9) < 7);
      en = $urandom_range(0, 1) == 1;
      step(se, en, 8'($urandom), 2'($urandom), "rand");
      if ($urandom_range(0, 49) == 0) reset_mid("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scan_reg_bank.md
# scan_reg_bank

Parametrised multi-bit scan register bank with asynchronous active-low reset, the multi-chain successor to the single-bit scan flop with reset. It holds WIDTH functional bits, splits them into NCHAIN equal scan segments with independent serial in/out, and counts shift cycles to flag a completed chain unload. An optional parity shadow bit detects corruption of the held word. It sits on register-file and configuration boundaries where a flop array must also be on the DFT scan path.

## Interface
- WIDTH, 8: functional bits held; must be a multiple of NCHAIN.
- NCHAIN, 1: number of scan segments; SEG = WIDTH/NCHAIN bits each.
- CLK input 1: single clock, rising-edge.
- RN input 1: reset, asynchronous, active-low.
- SE input 1: scan enable; 1 = shift, 0 = functional.
- SI input NCHAIN: serial input per segment.
- EN input 1: functional load enable.
- D input WIDTH: functional data.
- Q output WIDTH: held word.
- SO output NCHAIN: serial output per segment.
- SDONE output 1: one-cycle pulse, full chain length shifted.
- PERR output 1: parity mismatch; present only with SCAN_REG_PARITY_EN, otherwise tied 0.

## Operation
- Priority on each rising CLK edge: RN low > SE=1 shift > EN=1 load D > hold.
- RN low, at any time including mid-shift: Q=0, parity bit P=0, shift counter=0, SDONE=0, PERR=0, SO=0, immediately and without waiting for a clock.
- Segment c covers Q[c*SEG +: SEG]. On a shift edge, SI[c] enters Q[c*SEG+SEG-1], each bit takes its upper neighbour, and SO[c] = Q[c*SEG]. With parity compiled in, segment 0 becomes SI[0] -> Q[SEG-1] ... Q[0] -> P, and SO[0] = P.
- CHAIN_LEN = SEG+1 with parity, SEG without.
- Functional load: Q <= D, P <= XOR(D).
- Shift counter: width clog2(CHAIN_LEN+1). It increments on each shift edge. On the edge where it equals CHAIN_LEN-1 it wraps to 0 and SDONE is set for the following cycle. Any edge with SE=0 clears it to 0. A partial shift therefore never accumulates across SE gaps.
- SE and EN both high: shift only; D is ignored.

## Timing
- Q, SO and P are registered, so Q updates one edge after SE or EN is sampled.
- SO is taken directly from the register with no combinational path from SI.
- SDONE is registered: high exactly one cycle after the CHAIN_LEN-th consecutive shift edge, low otherwise. Back-to-back unloads produce a pulse every CHAIN_LEN cycles.
- PERR = XOR(Q) ^ P. It is combinational from registers and valid one cycle after any load or shift.

## Configuration
- SCAN_REG_PARITY_EN defined: adds the P register and the PERR output, and lengthens segment 0 and CHAIN_LEN by one bit.
- SCAN_REG_PARITY_EN undefined: no P register, PERR driven 0, CHAIN_LEN = SEG, and SO[0] = Q[0].

## Structure
- Package scan_reg_pkg holds:
  - the chain_len(SEG, parity) function;
  - the counter width function;
  - the reset value constant (all zero).
- One sub-module, scan_reg_seg: a SEG-bit shift/load segment with SI, SO, EN, SE and asynchronous RN.
- The top level instantiates NCHAIN segments, the parity bit, the shift counter and SDONE.

## Test plan
All scenarios use WIDTH=8, NCHAIN=2, SEG=4.
- Reset mid-shift: Q=0xA5, SE=1, pull RN low between edges -> Q=0x00, SO=2'b00, SDONE=0 before the next edge. Release RN -> the counter restarts from 0.
- Load/hold: SE=0, EN=1, D=0xA5 -> Q=0xA5. Then EN=0, D=0xFF -> Q stays 0xA5.
- Unload (no parity): Q=0xA5, SE=1, SI=2'b00 for 4 cycles:
  - SO[0] = 1,0,1,0 and SO[1] = 0,1,0,1;
  - Q ends at 0x00;
  - SDONE is high only in cycle 5.
- Simultaneous SE=1, EN=1, D=0xFF on Q=0x00, SI=2'b11 -> Q=0x88 (shift wins).
- Partial shift: SE=1 for 2 cycles, SE=0 for 1 cycle, then SE=1 -> SDONE only after 4 further consecutive shifts.
- Parity (macro defined):
  - Load 0x07 -> P=1, PERR=0.
  - 5-cycle loopback of SO into SI -> Q=0x07, PERR=0, SDONE in cycle 6.
  - Repeat with SI[1] forced to 1 on one cycle -> PERR=1.
